// File: rtl/ext_in_cntrl_pkg.sv
// Shared opcode constants for the execute-stage control blocks.
// Also holds the IN request decode used by the external input port.
package ext_in_cntrl_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_NOP   = 4'h0;
  localparam logic [OP_W-1:0] OP_ADD   = 4'h1;
  localparam logic [OP_W-1:0] OP_SUB   = 4'h2;
  localparam logic [OP_W-1:0] OP_AND   = 4'h3;
  localparam logic [OP_W-1:0] OP_OR    = 4'h4;
  localparam logic [OP_W-1:0] OP_XOR   = 4'h5;
  localparam logic [OP_W-1:0] OP_OUT   = 4'h6;
  localparam logic [OP_W-1:0] OP_IN    = 4'h7;
  localparam logic [OP_W-1:0] OP_LDI   = 4'h8;
  localparam logic [OP_W-1:0] OP_MOV   = 4'h9;
  localparam logic [OP_W-1:0] OP_JMP   = 4'ha;
  localparam logic [OP_W-1:0] OP_JZ    = 4'hb;
  localparam logic [OP_W-1:0] OP_CMP   = 4'hc;
  localparam logic [OP_W-1:0] OP_LOAD  = 4'hd;
  localparam logic [OP_W-1:0] OP_STORE = 4'he;
  localparam logic [OP_W-1:0] OP_HALT  = 4'hf;

  // A real (non-bubble) IN instruction sits in EXE.
  function automatic logic is_in_req(input logic ins_valid, input logic [OP_W-1:0] op);
    return ins_valid && (op == OP_IN);
  endfunction

endpackage

// File: rtl/ext_in_cntrl_byte_fifo.sv
// Parameterised synchronous FIFO with show-ahead read.
// Push is ignored when full, pop is ignored when empty.
module byte_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Pointers wrap naturally modulo DEPTH; count carries the extra bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem    <= '{default: '0};
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count   = r_count;

endmodule

// File: rtl/ext_in_cntrl.sv
// External input port controller for the IN instruction: buffers producer
// bytes and supplies them to write-back, stalling IN on an empty buffer.
module ext_in_cntrl
  import ext_in_cntrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       ext_data,
  input  logic                   ext_valid,
  output logic                   ext_ready,
  input  logic [OP_W-1:0]        op,
  input  logic                   ins_valid,
  output logic [WIDTH-1:0]       in_data,
  output logic                   stall,
  output logic [$clog2(DEPTH):0] count
);

  logic w_in_req;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_in_req  = is_in_req(ins_valid, op);
  // Ready depends only on occupancy and reset, never on the opcode.
  assign ext_ready = !w_full && !rst;
  assign w_push    = ext_valid && ext_ready;
  assign w_pop     = w_in_req && !w_empty;
  assign stall     = w_in_req && w_empty;

  byte_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_wr_data (ext_data),
    .i_pop     (w_pop),
    .o_rd_data (in_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (count)
  );

endmodule

// File: tb/tb_ext_in_cntrl.sv
// Scoreboard bench for ext_in_cntrl: directed scenarios then random traffic,
// checked against a queue-based model of the buffered bytes.
module tb_ext_in_cntrl;

  localparam int DEPTH = 4;
  localparam logic [3:0] OPIN = 4'h7;

  logic       clk;
  logic       rst;
  logic [7:0] ext_data;
  logic       ext_valid;
  logic       ext_ready;
  logic [3:0] op;
  logic       ins_valid;
  logic [7:0] in_data;
  logic       stall;
  logic [2:0] count;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] exp_q[$];
  logic       accepted = 1'b0;

  ext_in_cntrl #(.DEPTH(DEPTH), .WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .ext_data  (ext_data),
    .ext_valid (ext_valid),
    .ext_ready (ext_ready),
    .op        (op),
    .ins_valid (ins_valid),
    .in_data   (in_data),
    .stall     (stall),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model + scoreboard, sampled mid-cycle while inputs are stable.
  always @(negedge clk) begin
    int         cnt;
    logic       req;
    logic [7:0] exp_b;
    if (rst) begin
      exp_q.delete();
      accepted = 1'b0;
      chk("rst_ready", int'(ext_ready), 0);
      chk("rst_count", int'(count), 0);
      chk("rst_in_data", int'(in_data), 0);
    end else begin
      cnt = exp_q.size();
      req = ins_valid && (op == OPIN);
      chk("ext_ready", int'(ext_ready), (cnt < DEPTH) ? 1 : 0);
      chk("count", int'(count), cnt);
      chk("stall", int'(stall), (req && cnt == 0) ? 1 : 0);
      if (req && cnt > 0) begin
        exp_b = exp_q.pop_front();
        chk("in_data_pop", int'(in_data), int'(exp_b));
      end else if (cnt == 0) begin
        chk("in_data_empty", int'(in_data), 0);
      end
      // Acceptance decided on pre-edge occupancy; new byte visible next cycle.
      accepted = ext_valid && (cnt < DEPTH);
      if (accepted) exp_q.push_back(ext_data);
    end
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic [3:0] o, input logic iv);
    ext_valid = v;
    ext_data  = d;
    op        = o;
    ins_valid = iv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ext_valid = 1'b0; ext_data = 8'h00; op = 4'h1; ins_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle after reset
    drive(1'b0, 8'h00, 4'h1, 1'b1);
    drive(1'b0, 8'h00, 4'h1, 1'b1);

    // Push then IN one cycle later
    drive(1'b1, 8'hA5, 4'h1, 1'b1);
    drive(1'b0, 8'h00, OPIN, 1'b1);
    drive(1'b0, 8'h00, 4'h1, 1'b1);

    // IN stalls on empty, released by a push
    repeat (3) drive(1'b0, 8'h00, OPIN, 1'b1);
    drive(1'b1, 8'h3C, OPIN, 1'b1);
    drive(1'b0, 8'h00, OPIN, 1'b1);
    drive(1'b0, 8'h00, 4'h1, 1'b1);

    // Fill to full, fifth byte held until a pop frees a slot
    for (int i = 1; i <= 4; i++) drive(1'b1, 8'(i), 4'h1, 1'b1);
    drive(1'b1, 8'h05, OPIN, 1'b1);
    drive(1'b1, 8'h05, 4'h1, 1'b1);
    repeat (4) drive(1'b0, 8'h00, OPIN, 1'b1);
    drive(1'b0, 8'h00, 4'h1, 1'b0);

    // Streaming push and IN every cycle across pointer wrap
    for (int i = 0; i < 10; i++) drive(1'b1, 8'h10 + 8'(i), OPIN, 1'b1);
    drive(1'b0, 8'h00, OPIN, 1'b1);
    drive(1'b0, 8'h00, 4'h1, 1'b1);

    // Reset with three bytes buffered
    for (int i = 0; i < 3; i++) drive(1'b1, 8'hC0 + 8'(i), 4'h1, 1'b1);
    ext_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_now_count", int'(count), 0);
    chk("rst_now_ready", int'(ext_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) drive(1'b0, 8'h00, OPIN, 1'b1);
    drive(1'b1, 8'h77, OPIN, 1'b1);
    drive(1'b0, 8'h00, OPIN, 1'b1);
    drive(1'b0, 8'h00, 4'h1, 1'b1);

    // Random traffic; producer holds an offered byte until accepted
    for (int i = 0; i < 400; i++) begin
      logic       v;
      logic [7:0] d;
      logic [3:0] o;
      if (ext_valid && !accepted) begin
        v = 1'b1;
        d = ext_data;
      end else begin
        v = ($urandom_range(0, 2) != 0);
        d = 8'($urandom);
      end
      o = ($urandom_range(0, 2) == 0) ? OPIN : 4'($urandom);
      drive(v, d, o, ($urandom_range(0, 3) != 0));
    end

    drive(1'b0, 8'h00, 4'h1, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
